// File: rtl/calc_sequencer.sv
// Control sequencer for the 4-bit calculator: button conditioning, operand capture,
// ALU start/done handshake with timeout, and display/LED selection.
module calc_sequencer #(
  parameter int unsigned IN_WIDTH        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned ALU_TIMEOUT     = 64,
  parameter int unsigned LED_WIDTH       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_number,
  input  logic [1:0]           key,
  input  logic [3:0]           arif,
  output logic [IN_WIDTH-1:0]  alu_a,
  output logic [IN_WIDTH-1:0]  alu_b,
  output logic [1:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic                 alu_error,
  output logic                 disp_sel,
  output logic                 disp_error,
  output logic [LED_WIDTH-1:0] led
);

  localparam int unsigned NumBtn = 6;
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmoW   = $clog2(ALU_TIMEOUT + 1);

  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ALU_TIMEOUT - 1);

  localparam logic [LED_WIDTH-1:0] LedIdle  = LED_WIDTH'(3'b110);
  localparam logic [LED_WIDTH-1:0] LedHaveA = LED_WIDTH'(3'b101);
  localparam logic [LED_WIDTH-1:0] LedHaveB = LED_WIDTH'(3'b011);
  localparam logic [LED_WIDTH-1:0] LedExec  = LED_WIDTH'(3'b110);
  localparam logic [LED_WIDTH-1:0] LedShow  = LED_WIDTH'(3'b110);

  typedef enum logic [2:0] {StIdle, StHaveA, StHaveB, StExec, StShow} state_e;

  logic [NumBtn-1:0]   btn_meta_q, btn_sync_q, btn_press;
  logic [IN_WIDTH-1:0] num_meta_q, num_sync_q, operand;
  logic [1:0]          key_press;
  logic [3:0]          arif_press;
  logic [1:0]          op_sel;
  state_e              state_q;
  logic [TmoW-1:0]     tmo_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q <= '1;
      btn_sync_q <= '1;
      num_meta_q <= '1;
      num_sync_q <= '1;
    end else begin
      btn_meta_q <= {arif, key};
      btn_sync_q <= btn_meta_q;
      num_meta_q <= in_number;
      num_sync_q <= num_meta_q;
    end
  end

  // Independent debouncer per button; press fires on the last of DEBOUNCE_CYCLES low samples.
  for (genvar i = 0; i < NumBtn; i++) begin : g_db
    logic           level_q;
    logic [DbW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        level_q <= 1'b1;
        cnt_q   <= '0;
      end else if (btn_sync_q[i] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DbLast) begin
        cnt_q   <= '0;
        level_q <= btn_sync_q[i];
      end else begin
        cnt_q <= cnt_q + DbW'(1);
      end
    end

    assign btn_press[i] = level_q & ~btn_sync_q[i] & (cnt_q == DbLast);
  end

  assign key_press  = btn_press[1:0];
  assign arif_press = btn_press[5:2];
  assign operand    = ~num_sync_q;

  // Lowest-index operation button wins on simultaneous presses.
  always_comb begin
    op_sel = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (arif_press[i]) op_sel = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      disp_sel   <= 1'b0;
      disp_error <= 1'b0;
      led        <= LedIdle;
      tmo_q      <= '0;
    end else begin
      alu_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (key_press[0]) begin
            alu_a   <= operand;
            state_q <= StHaveA;
            led     <= LedHaveA;
          end
        end
        StHaveA: begin
          if (key_press[0]) begin
            alu_a <= operand;
          end else if (key_press[1]) begin
            alu_b   <= operand;
            state_q <= StHaveB;
            led     <= LedHaveB;
          end
        end
        StHaveB: begin
          if (key_press[0]) begin
            alu_a   <= operand;
            state_q <= StHaveA;
            led     <= LedHaveA;
          end else if (key_press[1]) begin
            alu_b <= operand;
          end else if (|arif_press) begin
            alu_op    <= op_sel;
            alu_start <= 1'b1;
            tmo_q     <= '0;
            state_q   <= StExec;
            led       <= LedExec;
          end
        end
        StExec: begin
          tmo_q <= tmo_q + TmoW'(1);
          // alu_start is high only in the first EXEC cycle; a done pulse there is ignored.
          if (alu_done && !alu_start) begin
            disp_error <= alu_error;
            disp_sel   <= 1'b1;
            state_q    <= StShow;
            led        <= LedShow;
          end else if (tmo_q == TmoLast) begin
            disp_error <= 1'b1;
            disp_sel   <= 1'b1;
            state_q    <= StShow;
            led        <= LedShow;
          end
        end
        StShow: begin
          if (key_press[0]) begin
            alu_a      <= operand;
            disp_error <= 1'b0;
            disp_sel   <= 1'b0;
            state_q    <= StHaveA;
            led        <= LedHaveA;
          end
        end
        default: begin
          state_q <= StIdle;
          led     <= LedIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control FSM for the 4-bit calculator. It debounces the active-low enter and arithmetic buttons and captures the two operands from the active-low switch bank. It then launches one operation on the shared arithmetic unit through a start/done handshake and selects what the 7-segment display driver shows. It sits between the board pins (`in_number`, `key`, `arif`) and the arithmetic datapath/display multiplexer, and owns the `led` status outputs.

## Interface
Parameters:
- `IN_WIDTH`, 4, operand width
- `DEBOUNCE_CYCLES`, 10000, number of consecutive stable synchronized samples (200 us at 50 MHz) before a level is accepted
- `ALU_TIMEOUT`, 64, maximum number of cycles in EXEC before the operation is aborted
- `LED_WIDTH`, 3, status LED width

Ports (clock and reset first):
- `clk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  reset, synchronous, active-low
- `in_number`  in  IN_WIDTH  operand switches, active-low; the operand value is `~in_number`
- `key`  in  2  enter buttons, active-low; `key[0]` = enter A, `key[1]` = enter B
- `arif`  in  4  operation buttons, active-low; bit 0 = +, bit 1 = −, bit 2 = ×, bit 3 = ÷
- `alu_a`  out  IN_WIDTH  captured operand A
- `alu_b`  out  IN_WIDTH  captured operand B
- `alu_op`  out  2  operation code: 0 = +, 1 = −, 2 = ×, 3 = ÷
- `alu_start`  out  1  one-cycle start pulse to the arithmetic unit
- `alu_done`  in  1  one-cycle completion pulse from the arithmetic unit
- `alu_error`  in  1  error flag, qualified by `alu_done` (e.g. divide by zero)
- `disp_sel`  out  1  display source: 0 = live switches, 1 = arithmetic result
- `disp_error`  out  1  display driver shows "E"; meaningful only when `disp_sel` = 1
- `led`  out  LED_WIDTH  status LEDs, active-low

## Operation
Input conditioning:
- Each of the 6 button inputs passes through a 2-flop synchronizer and then an independent debounce counter.
- A debounced level updates only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
- A press event is a one-cycle pulse on a debounced 1→0 transition. Releases generate no event.
- `in_number` is synchronized with 2 flops only, with no debounce, and is sampled at the event cycle.

State machine (states, LED value, and transitions):
- IDLE, `led` = 110:
  - `key[0]` event: capture `alu_a` = `~in_number`, go to HAVE_A.
- HAVE_A, `led` = 101:
  - `key[1]` event: capture `alu_b`, go to HAVE_B.
  - `key[0]` event: recapture `alu_a`, stay in HAVE_A.
  - `arif` events: ignored.
- HAVE_B, `led` = 011:
  - `arif` event: latch `alu_op`, go to EXEC.
  - `key[1]` event: recapture `alu_b`, stay in HAVE_B.
  - `key[0]` event: recapture `alu_a`, return to HAVE_A (B must be re-entered).
- EXEC, `led` = 110:
  - `alu_start` is high for the first cycle only.
  - `alu_done` received: go to SHOW with `disp_error` = `alu_error`.
  - Timeout counter reaches ALU_TIMEOUT: go to SHOW with `disp_error` = 1.
  - All button events in this state are dropped, not queued.
- SHOW, `led` = 110, `disp_sel` = 1:
  - `key[0]` event: capture `alu_a`, clear `disp_error`, go to HAVE_A.
  - Other events: ignored.

Outputs and event priority:
- `disp_sel` = 0 in every state except SHOW.
- Simultaneous `key[0]` and `key[1]` events: `key[0]` wins and `key[1]` is discarded.
- Several `arif` events in the same cycle: the lowest index wins (+ over − over × over ÷).
- `alu_a`, `alu_b` and `alu_op` are held constant from EXEC entry until the next capture.

Reset values (`rst_n` low at a clock edge):
- State = IDLE.
- `alu_a` = `alu_b` = 0, `alu_op` = 0.
- `alu_start` = 0, `disp_sel` = 0, `disp_error` = 0.
- `led` = 110.
- Debounced levels = 1 (released); debounce and timeout counters = 0.
- Reset mid-EXEC aborts the operation. A late `alu_done` arriving after reset is ignored because the state is IDLE.

## Timing
- Pin to event: 2 synchronizer cycles + DEBOUNCE_CYCLES.
- The state, operand capture and `led` update are registered and visible one cycle after the event pulse.
- `alu_start` is high exactly in the first EXEC cycle, i.e. one cycle after the `arif` event.
- `alu_done` is accepted at the earliest in the cycle after `alu_start`. `alu_done` coinciding with `alu_start` is ignored.
- `alu_done` and timeout expiry in the same cycle: `alu_done` wins, and `disp_error` = `alu_error`.
- SHOW (`disp_sel` = 1) is entered on the cycle after `alu_done`.
- The timeout counter clears on EXEC entry and counts EXEC cycles. Expiry occurs on the ALU_TIMEOUT-th cycle.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.
- A button held down generates exactly one event.

## Test plan
1. Reset, then `key[0]` press with `in_number` = 4'b1010 → `alu_a` = 5, `led` = 101, `disp_sel` = 0.
2. A = 9, B = 3 (`in_number` = 4'b1100), press `arif[1]` → `alu_op` = 1, a single `alu_start` pulse, `led` = 110. Stub `alu_done` after 5 cycles → `disp_sel` = 1 one cycle later, `disp_error` = 0.
3. A = 7, B = 0, press ÷ with the stub returning `alu_done` and `alu_error` → `disp_error` = 1. Then `key[0]` press → `disp_error` = 0, `led` = 101.
4. Stub never asserts `alu_done` → SHOW after ALU_TIMEOUT = 64 cycles with `disp_error` = 1. Button presses during EXEC cause no state change.
5. Bounce: `key[1]` toggled every 100 cycles for 2000 cycles then held low, in HAVE_A → exactly one capture, after DEBOUNCE_CYCLES of stable low. `arif[0]` and `arif[3]` pressed in the same cycle → `alu_op` = 0.
6. Assert `rst_n` low for 1 cycle mid-EXEC → IDLE, all outputs at reset values. A later `alu_done` pulse leaves `disp_sel` = 0.
